// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// The master modport is the pipeline, which supplies hazard inputs and consumes stage controls.
interface hazard_stall_controller_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_uses_rs;
  logic        ID_uses_rt;
  logic        EX_MemRead;
  logic [4:0]  EX_rd;
  logic        EX_branch_taken;
  logic        MEM_mem_req;
  logic        MEM_mem_ready;
  logic        halt_req;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        EX_MEM_Write;
  logic        MEM_WB_Bubble;
  logic [2:0]  state;
  logic [15:0] stall_cycles;
  logic        mem_timeout_err;

  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_MemRead, EX_rd,
           EX_branch_taken, MEM_mem_req, MEM_mem_ready, halt_req,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write,
           MEM_WB_Bubble, state, stall_cycles, mem_timeout_err
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_MemRead, EX_rd,
           EX_branch_taken, MEM_mem_req, MEM_mem_ready, halt_req,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write,
           MEM_WB_Bubble, state, stall_cycles, mem_timeout_err
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch flushes,
// data-memory waits with timeout, and a drain-then-halt sequence.
module hazard_stall_controller #(
  parameter int         MEM_TIMEOUT  = 16,
  parameter int         DRAIN_CYCLES = 3,
  parameter logic [4:0] REG_ZERO     = 5'd31
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hazard_stall_controller_if.slave    bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [WW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [15:0]     stall_reg;
  logic            err_reg, err_next;

  logic memwait, loaduse;
  logic pc_w, ifid_w, ifid_f, idex_f, exmem_w, memwb_b;

  assign memwait = bus.MEM_mem_req & ~bus.MEM_mem_ready;
  assign loaduse = bus.EX_MemRead && (bus.EX_rd != REG_ZERO) &&
                   ((bus.ID_uses_rs && (bus.EX_rd == bus.ID_rs)) ||
                    (bus.ID_uses_rt && (bus.EX_rd == bus.ID_rt)));

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    err_next       = err_reg;
    pc_w           = 1'b0;
    ifid_w         = 1'b0;
    ifid_f         = 1'b0;
    idex_f         = 1'b0;
    exmem_w        = 1'b0;
    memwb_b        = 1'b0;
    case (state_reg)
      RUN, MEM_WAIT: begin
        if (state_reg == MEM_WAIT && !bus.MEM_mem_ready) begin
          memwb_b = 1'b1;
          if (wait_cnt_reg >= WW'(MEM_TIMEOUT - 1)) begin
            state_next    = HALTED;
            err_next      = 1'b1;
            wait_cnt_next = WW'(MEM_TIMEOUT);
          end else begin
            wait_cnt_next = wait_cnt_reg + WW'(1);
          end
        end else begin
          // A released wait behaves as a RUN cycle; memwait is already false here.
          state_next = RUN;
          pc_w       = 1'b1;
          ifid_w     = 1'b1;
          exmem_w    = 1'b1;
          if (memwait) begin
            pc_w          = 1'b0;
            ifid_w        = 1'b0;
            exmem_w       = 1'b0;
            memwb_b       = 1'b1;
            state_next    = MEM_WAIT;
            wait_cnt_next = WW'(1);
          end else if (bus.EX_branch_taken) begin
            ifid_f = 1'b1;
            idex_f = 1'b1;
          end else if (loaduse) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_f = 1'b1;
          end else if (bus.halt_req) begin
            pc_w           = 1'b0;
            ifid_f         = 1'b1;
            state_next     = DRAIN;
            drain_cnt_next = DW'(1);
          end
        end
      end
      DRAIN: begin
        if (memwait) begin
          memwb_b = 1'b1;
        end else begin
          ifid_f  = 1'b1;
          idex_f  = 1'b1;
          exmem_w = 1'b1;
          if (drain_cnt_reg >= DW'(DRAIN_CYCLES)) begin
            state_next = HALTED;
          end else begin
            drain_cnt_next = drain_cnt_reg + DW'(1);
          end
        end
      end
      HALTED: begin
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      stall_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      err_reg       <= err_next;
      if (!pc_w && state_reg != HALTED && stall_reg != 16'hFFFF) begin
        stall_reg <= stall_reg + 16'd1;
      end
    end
  end

  // Controls are forced low while reset is held, independent of state.
  assign bus.PC_Write        = rst_n & pc_w;
  assign bus.IF_ID_Write     = rst_n & ifid_w;
  assign bus.IF_ID_Flush     = rst_n & ifid_f;
  assign bus.ID_EX_Flush     = rst_n & idex_f;
  assign bus.EX_MEM_Write    = rst_n & exmem_w;
  assign bus.MEM_WB_Bubble   = rst_n & memwb_b;
  assign bus.state           = state_reg;
  assign bus.stall_cycles    = stall_reg;
  assign bus.mem_timeout_err = err_reg;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_hazard_stall_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_controller_if hs ();
  hazard_stall_controller dut (.clk(clk), .rst_n(rst_n), .bus(hs));

  // Output vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble}
  localparam logic [5:0] O_RUN = 6'b110010;
  localparam logic [5:0] O_LU  = 6'b000110;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_FRZ = 6'b000001;
  localparam logic [5:0] O_HRQ = 6'b011010;
  localparam logic [5:0] O_DRN = 6'b001110;
  localparam logic [5:0] O_OFF = 6'b000000;

  typedef struct {
    string       nm;
    logic [5:0]  o;
    logic [2:0]  st;
    logic [15:0] sc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic idle();
    hs.ID_rs = 5'd0; hs.ID_rt = 5'd0; hs.ID_uses_rs = 1'b0; hs.ID_uses_rt = 1'b0;
    hs.EX_MemRead = 1'b0; hs.EX_rd = 5'd0; hs.EX_branch_taken = 1'b0;
    hs.MEM_mem_req = 1'b0; hs.MEM_mem_ready = 1'b0; hs.halt_req = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic urs);
    hs.EX_MemRead = 1'b1; hs.EX_rd = rd; hs.ID_rs = rs; hs.ID_uses_rs = urs;
  endtask

  task automatic cyc(input string nm, input logic [5:0] o, input logic [2:0] st,
                     input int sc, input logic err);
    exp_t e;
    e.nm = nm; e.o = o; e.st = st; e.sc = 16'(sc); e.err = err;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] ao;
      e  = exp_q.pop_front();
      ao = {hs.PC_Write, hs.IF_ID_Write, hs.IF_ID_Flush, hs.ID_EX_Flush,
            hs.EX_MEM_Write, hs.MEM_WB_Bubble};
      $display("[TB] %s ctl=%b state=%0d stall=%0d err=%0b", e.nm, ao, hs.state,
               hs.stall_cycles, hs.mem_timeout_err);
      tests++;
      if (ao !== e.o) begin
        fails++; $display("FAIL %s ctl: got %b want %b", e.nm, ao, e.o);
      end
      tests++;
      if (hs.state !== e.st) begin
        fails++; $display("FAIL %s state: got %0d want %0d", e.nm, hs.state, e.st);
      end
      tests++;
      if (hs.stall_cycles !== e.sc) begin
        fails++; $display("FAIL %s stall_cycles: got %0d want %0d", e.nm, hs.stall_cycles, e.sc);
      end
      tests++;
      if (hs.mem_timeout_err !== e.err) begin
        fails++; $display("FAIL %s mem_timeout_err: got %0b want %0b", e.nm, hs.mem_timeout_err, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    set_lu(5'd5, 5'd5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", O_OFF, 3'd0, 0, 1'b0);
    cyc("reset", O_OFF, 3'd0, 0, 1'b0);
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc("idle", O_RUN, 3'd0, 0, 1'b0);

    // Load-use on rs, then EX_rd = REG_ZERO never stalls
    set_lu(5'd5, 5'd5, 1'b1);            cyc("loaduse_rs", O_LU, 3'd0, 0, 1'b0);
    set_lu(5'd31, 5'd31, 1'b1);          cyc("loaduse_r31", O_RUN, 3'd0, 1, 1'b0);
    idle(); hs.EX_MemRead = 1'b1; hs.EX_rd = 5'd7; hs.ID_rt = 5'd7; hs.ID_uses_rt = 1'b1;
    cyc("loaduse_rt", O_LU, 3'd0, 1, 1'b0);
    hs.ID_uses_rt = 1'b0;                cyc("rt_unused", O_RUN, 3'd0, 2, 1'b0);
    idle();                              cyc("idle", O_RUN, 3'd0, 2, 1'b0);

    // Branch outranks load-use and halt
    set_lu(5'd5, 5'd5, 1'b1); hs.EX_branch_taken = 1'b1;
    cyc("branch_lu", O_BR, 3'd0, 2, 1'b0);
    idle(); hs.EX_branch_taken = 1'b1; hs.halt_req = 1'b1;
    cyc("branch_halt", O_BR, 3'd0, 2, 1'b0);
    idle();                              cyc("idle", O_RUN, 3'd0, 2, 1'b0);

    // Four frozen cycles, release on ready
    hs.MEM_mem_req = 1'b1;
    cyc("memwait", O_FRZ, 3'd0, 2, 1'b0);
    cyc("memwait", O_FRZ, 3'd1, 3, 1'b0);
    cyc("memwait", O_FRZ, 3'd1, 4, 1'b0);
    cyc("memwait", O_FRZ, 3'd1, 5, 1'b0);
    hs.MEM_mem_ready = 1'b1;             cyc("mem_ready", O_RUN, 3'd1, 6, 1'b0);
    idle();                              cyc("idle", O_RUN, 3'd0, 6, 1'b0);

    // Held load-use acted on at release
    hs.MEM_mem_req = 1'b1; set_lu(5'd9, 5'd9, 1'b1);
    cyc("memwait_lu", O_FRZ, 3'd0, 6, 1'b0);
    hs.MEM_mem_ready = 1'b1;             cyc("release_lu", O_LU, 3'd1, 7, 1'b0);
    idle();                              cyc("idle", O_RUN, 3'd0, 8, 1'b0);

    // Held branch outranks load-use at release
    hs.MEM_mem_req = 1'b1; set_lu(5'd9, 5'd9, 1'b1); hs.EX_branch_taken = 1'b1;
    cyc("memwait_br", O_FRZ, 3'd0, 8, 1'b0);
    hs.MEM_mem_ready = 1'b1;             cyc("release_br", O_BR, 3'd1, 9, 1'b0);
    idle();                              cyc("idle", O_RUN, 3'd0, 9, 1'b0);

    // Halt with a memory wait inside the drain
    hs.halt_req = 1'b1;                  cyc("halt_req", O_HRQ, 3'd0, 9, 1'b0);
    cyc("drain1", O_DRN, 3'd2, 10, 1'b0);
    hs.MEM_mem_req = 1'b1;               cyc("drain_frz", O_FRZ, 3'd2, 11, 1'b0);
    hs.MEM_mem_req = 1'b0;               cyc("drain2", O_DRN, 3'd2, 12, 1'b0);
    cyc("drain3", O_DRN, 3'd2, 13, 1'b0);
    cyc("halted", O_OFF, 3'd3, 14, 1'b0);
    hs.halt_req = 1'b0;                  cyc("halted_nohalt", O_OFF, 3'd3, 14, 1'b0);
    hs.MEM_mem_req = 1'b1;               cyc("halted_memreq", O_OFF, 3'd3, 14, 1'b0);
    idle();

    // Reset clears halt; then reset asserted mid-drain
    rst_n = 1'b0;                        cyc("reset_halted", O_OFF, 3'd0, 0, 1'b0);
    rst_n = 1'b1;
    hs.halt_req = 1'b1;                  cyc("halt_req", O_HRQ, 3'd0, 0, 1'b0);
    cyc("drain1", O_DRN, 3'd2, 1, 1'b0);
    cyc("drain2", O_DRN, 3'd2, 2, 1'b0);
    rst_n = 1'b0;                        cyc("reset_drain", O_OFF, 3'd0, 0, 1'b0);
    idle(); rst_n = 1'b1;                cyc("idle", O_RUN, 3'd0, 0, 1'b0);

    // Memory timeout
    hs.MEM_mem_req = 1'b1;
    cyc("to_start", O_FRZ, 3'd0, 0, 1'b0);
    for (int k = 1; k <= 15; k++) cyc("to_wait", O_FRZ, 3'd1, k, 1'b0);
    cyc("timeout", O_OFF, 3'd3, 16, 1'b1);
    hs.MEM_mem_ready = 1'b1;             cyc("timeout_hold", O_OFF, 3'd3, 16, 1'b1);
    idle();                              cyc("timeout_hold", O_OFF, 3'd3, 16, 1'b1);
    rst_n = 1'b0;                        cyc("reset_err", O_OFF, 3'd0, 0, 1'b0);
    rst_n = 1'b1;                        cyc("idle", O_RUN, 3'd0, 0, 1'b0);

    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Sits beside the EX-stage forwarding logic and resolves the hazards forwarding cannot:
  - load-use stalls
  - taken-branch flushes
  - multi-cycle data-memory waits
  - controlled halt/drain
- Drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before timeout error.
- DRAIN_CYCLES, 3: cycles spent draining in-flight instructions before HALTED.
- REG_ZERO, 5'd31: hardwired register index; never a hazard source.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ID_rs  input  5  source register A of instruction in ID.
- ID_rt  input  5  source register B of instruction in ID.
- ID_uses_rs  input  1  ID instruction reads rs.
- ID_uses_rt  input  1  ID instruction reads rt.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_rd  input  5  destination register of instruction in EX.
- EX_branch_taken  input  1  branch in EX resolved taken.
- MEM_mem_req  input  1  instruction in MEM accesses data memory.
- MEM_mem_ready  input  1  data memory completes access this cycle.
- halt_req  input  1  level request to stop the core.
- PC_Write  output  1  PC register load enable.
- IF_ID_Write  output  1  IF/ID load enable.
- IF_ID_Flush  output  1  clear IF/ID to NOP.
- ID_EX_Flush  output  1  clear ID/EX to bubble.
- EX_MEM_Write  output  1  EX/MEM load enable.
- MEM_WB_Bubble  output  1  load bubble into MEM/WB.
- state  output  3  current FSM state (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3).
- stall_cycles  output  16  count of cycles with PC_Write=0, excluding HALTED.
- mem_timeout_err  output  1  sticky memory-timeout flag.

Behaviour:
- One clock domain (clk). rst_n is asynchronous, active-low.
- While rst_n=0:
  - state=RUN, stall_cycles=0, mem_timeout_err=0, wait and drain counters=0.
  - PC_Write, IF_ID_Write, EX_MEM_Write = 0.
  - IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble = 0.
- Control outputs are combinational from the registered state and current inputs. State and counters update on the rising edge of clk.
- Default outputs in RUN: PC_Write=1, IF_ID_Write=1, EX_MEM_Write=1, all flush/bubble=0.
- Hazard conditions evaluated in RUN:
  - memwait = MEM_mem_req & !MEM_mem_ready
  - loaduse = EX_MemRead & EX_rd!=REG_ZERO & ((ID_uses_rs & EX_rd==ID_rs) | (ID_uses_rt & EX_rd==ID_rt))
- RUN priority, highest first:
  1. memwait: freeze (PC_Write=0, IF_ID_Write=0, EX_MEM_Write=0, MEM_WB_Bubble=1). Next state MEM_WAIT; wait counter <= 1.
  2. EX_branch_taken: PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. Loaduse and halt_req are ignored this cycle because the ID instruction is wrong-path.
  3. loaduse: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Exactly one bubble; on the next cycle the load is in MEM and forwarding covers it.
  4. halt_req: PC_Write=0, IF_ID_Flush=1. Next state DRAIN; drain counter <= 1.
- MEM_WAIT:
  - While MEM_mem_ready=0: freeze outputs as in priority 1. Wait counter increments each cycle. EX_branch_taken and loaduse are held, not acted on.
  - If MEM_mem_ready=1: freeze released in the same cycle. Outputs are evaluated exactly as RUN, priorities 2–4; the branch/loaduse pending in EX/ID is acted on then. Next state RUN.
  - If the wait counter reaches MEM_TIMEOUT with ready still 0: next state HALTED and mem_timeout_err <= 1.
- DRAIN:
  - PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Write=1.
  - If memwait occurs, freeze as in MEM_WAIT (drain counter holds), then resume DRAIN.
  - After DRAIN_CYCLES unfrozen cycles, go to HALTED.
- HALTED:
  - All enables 0, all flush/bubble 0.
  - Exited only by reset. halt_req deassertion has no effect.
- stall_cycles: +1 on each clk edge where PC_Write=0 and state!=HALTED. Saturates at 16'hFFFF.
- mem_timeout_err: cleared only by reset.
- Reset mid-stall or mid-drain returns immediately and asynchronously to the reset values.

Test Plan:
- Reset release, no hazards, 10 cycles -> state=0; PC_Write=1, IF_ID_Write=1; flushes 0; stall_cycles=0.
- EX_MemRead=1, EX_rd=5, ID_rs=5, ID_uses_rs=1 for 1 cycle -> that cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Repeat with EX_rd=31 -> no stall. stall_cycles=1.
- EX_branch_taken=1 together with a loaduse match -> PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; no stall counted.
- MEM_mem_req=1, ready low for 4 cycles then high -> 4 frozen cycles with MEM_WB_Bubble=1, state=1; on the ready cycle outputs return to RUN; stall_cycles=4.
- MEM_mem_req=1, ready held low >=16 cycles -> state=3, mem_timeout_err=1. Both held until rst_n pulse clears to 0.
- halt_req=1 in RUN -> state=2 for 3 cycles with IF_ID_Flush=1, then state=3 with all enables 0. Assert rst_n=0 mid-DRAIN -> immediate return to reset values.
